// File: rtl/osd_spi_host_pkg.sv
// Shared OSD command constants and the host FSM state encoding.
package osd_spi_host_pkg;

    localparam logic [7:0] OSD_CMD_ACK      = 8'h00;
    localparam logic [7:0] OSD_CMD_DATA_IN  = 8'h10;
    localparam logic [7:0] OSD_CMD_CONF_STR = 8'h14;
    localparam logic [7:0] OSD_CMD_STATUS   = 8'h15;
    localparam logic [7:0] OSD_CMD_WRITE    = 8'h20;
    localparam logic [7:0] OSD_CMD_DISABLE  = 8'h40;
    localparam logic [7:0] OSD_CMD_ENABLE   = 8'h41;
    localparam logic [7:0] OSD_CMD_CONFIG   = 8'h60;
    localparam logic [7:0] OSD_CMD_PUMP     = 8'h61;
    localparam logic [7:0] OSD_CMD_PUMP_END = 8'h62;
    localparam logic [7:0] OSD_ACK_BYTE     = 8'h4B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_FETCH,
        ST_DATA,
        ST_END,
        ST_GAP_HI
    } osd_state_t;

endpackage

// File: rtl/osd_spi_host_if.sv
// Command, payload and status signals between a soft controller and osd_spi_host.
interface osd_spi_host_if #(
    parameter int LEN_W = 12
) ();
    import osd_spi_host_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_byte;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_rd;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_byte, cmd_len, cmd_rd, tx_valid, tx_data,
        input  cmd_ready, tx_ready, rx_valid, rx_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_byte, cmd_len, cmd_rd, tx_valid, tx_data,
        output cmd_ready, tx_ready, rx_valid, rx_data, busy, done
    );

endinterface

// File: rtl/osd_spi_shifter.sv
// SCK half-period divider plus mode-0 byte shifter: drive on falling edge, sample on rising edge.
module osd_spi_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       run,
    input  logic       restart,
    input  logic       shift_en,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       sdi,
    output logic       tick,
    output logic       last_rise,
    output logic       last_fall,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       sdo
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic [2:0]       bit_cnt;
    logic             rise;
    logic             fall;

    assign tick      = run && (div == '0);
    assign rise      = shift_en && tick && !sck;
    assign fall      = shift_en && tick && sck;
    assign last_rise = rise && (bit_cnt == 3'd7);
    assign last_fall = fall && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sh[6:0], sdi};
    assign sdo       = tx_sh[7];

    // Restart realigns the half-period so a byte loaded after a stall gets full setup time.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset)
            div <= DIV_LOAD;
        else if (!run || restart || (div == '0))
            div <= DIV_LOAD;
        else
            div <= div - DIV_W'(1);
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            sck     <= 1'b0;
            tx_sh   <= 8'h00;
            rx_sh   <= 8'h00;
            bit_cnt <= 3'd0;
        end else begin
            if (rise) begin
                sck   <= 1'b1;
                rx_sh <= {rx_sh[6:0], sdi};
            end
            if (fall) begin
                sck     <= 1'b0;
                tx_sh   <= {tx_sh[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (load) begin
                tx_sh   <= load_byte;
                bit_cnt <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/osd_spi_host.sv
// SPI mode-0 master for the OSD command channel: command byte, then cmd_len payload bytes.
module osd_spi_host
    import osd_spi_host_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 12,
    parameter int SS_GAP  = 2
) (
    input  logic           pclk,
    input  logic           reset,
    osd_spi_host_if.slave  bus,
    output logic           sck,
    output logic           ss,
    output logic           sdo,
    input  logic           sdi
);

    localparam int               GAP_W    = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SS_GAP - 1);

    osd_state_t       state, state_nxt;
    logic             rdy_en;
    logic             rd_q;
    logic [LEN_W-1:0] rem;
    logic [GAP_W-1:0] gap_cnt;
    logic             cmd_ready;
    logic             ld, rst_div, take, dec, start, end_xfer;
    logic [7:0]       ld_byte;
    logic             tick, last_rise, last_fall;
    logic [7:0]       rx_byte;
    logic             done_q, rx_valid_q;
    logic [7:0]       rx_data_q;

    assign cmd_ready     = rdy_en && (state == ST_IDLE);
    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.tx_ready  = take;
    assign bus.done      = done_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;

    osd_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .pclk      (pclk),
        .reset     (reset),
        .run       (state != ST_IDLE),
        .restart   (rst_div),
        .shift_en  ((state == ST_CMD) || (state == ST_DATA)),
        .load      (ld),
        .load_byte (ld_byte),
        .sdi       (sdi),
        .tick      (tick),
        .last_rise (last_rise),
        .last_fall (last_fall),
        .rx_byte   (rx_byte),
        .sck       (sck),
        .sdo       (sdo)
    );

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        ld_byte   = 8'h00;
        rst_div   = 1'b0;
        take      = 1'b0;
        dec       = 1'b0;
        start     = 1'b0;
        end_xfer  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    state_nxt = ST_SETUP;
                    start     = 1'b1;
                    ld        = 1'b1;
                    ld_byte   = bus.cmd_byte;
                end
            end
            ST_SETUP: begin
                if (tick)
                    state_nxt = ST_CMD;
            end
            // Loading at the last falling edge keeps back-to-back bytes free of extra half-periods.
            ST_CMD, ST_DATA: begin
                if (last_fall) begin
                    if (rem == '0) begin
                        state_nxt = ST_END;
                    end else if (rd_q || bus.tx_valid) begin
                        state_nxt = ST_DATA;
                        ld        = 1'b1;
                        dec       = 1'b1;
                        take      = !rd_q;
                        ld_byte   = rd_q ? 8'h00 : bus.tx_data;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (rd_q || bus.tx_valid) begin
                    state_nxt = ST_DATA;
                    ld        = 1'b1;
                    dec       = 1'b1;
                    rst_div   = 1'b1;
                    take      = !rd_q;
                    ld_byte   = rd_q ? 8'h00 : bus.tx_data;
                end
            end
            ST_END: begin
                if (tick) begin
                    state_nxt = ST_GAP_HI;
                    end_xfer  = 1'b1;
                end
            end
            ST_GAP_HI: begin
                if (tick && (gap_cnt == GAP_LAST))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rdy_en     <= 1'b0;
            ss         <= 1'b1;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rd_q       <= 1'b0;
            rem        <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            rdy_en     <= 1'b1;
            done_q     <= end_xfer;
            rx_valid_q <= (state == ST_DATA) && last_rise;
            if ((state == ST_DATA) && last_rise)
                rx_data_q <= rx_byte;
            if (start) begin
                ss   <= 1'b0;
                rd_q <= bus.cmd_rd;
                rem  <= bus.cmd_len;
            end else if (end_xfer) begin
                ss <= 1'b1;
            end
            if (dec)
                rem <= rem - LEN_W'(1);
            if (state != ST_GAP_HI)
                gap_cnt <= '0;
            else if (tick)
                gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_osd_spi_host.sv
// Bench for osd_spi_host: behavioural OSD slave, tx driver, rx scoreboard with monitor.
module tb_osd_spi_host;
    import osd_spi_host_pkg::*;

    logic pclk = 1'b0;
    logic reset;
    logic sck, ss, sdo, sdi;
    logic sck1, ss1, sdo1;
    logic sdi1 = 1'b0;

    osd_spi_host_if #(.LEN_W(12)) ifc ();
    osd_spi_host_if #(.LEN_W(12)) ifc1 ();

    osd_spi_host #(.CLK_DIV(4), .LEN_W(12), .SS_GAP(2)) dut (
        .pclk(pclk), .reset(reset), .bus(ifc), .sck(sck), .ss(ss), .sdo(sdo), .sdi(sdi));
    osd_spi_host #(.CLK_DIV(1), .LEN_W(12), .SS_GAP(2)) dut1 (
        .pclk(pclk), .reset(reset), .bus(ifc1), .sck(sck1), .ss(ss1), .sdo(sdo1), .sdi(sdi1));

    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;
    int sck_cnt, txr_cnt, done_cnt, rx_cnt, gap_cnt, popped, hold_at, hold_left;
    int sck1_cnt, txr1, done1, rx1, gap1;
    logic took;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural OSD slave: latches command, stores status, answers ACK payload with 0x4B.
    logic [7:0]  s_in, s_out, s_cmd;
    int          s_bits, s_idx;
    logic [31:0] s_acc, osd_status;
    logic        osd_enable;

    always @(negedge ss) begin
        s_bits = 0; s_idx = 0; s_out = 8'h00; s_acc = 32'h0; sdi = 1'b0;
    end
    always @(posedge sck) begin
        sck_cnt++;
        if (!ss) begin
            s_in = {s_in[6:0], sdo};
            s_bits++;
            if (s_bits == 8) begin
                s_bits = 0;
                if (s_idx == 0) begin
                    s_cmd = s_in;
                    if (s_in == OSD_CMD_ENABLE) osd_enable = 1'b1;
                    else if (s_in == OSD_CMD_DISABLE) osd_enable = 1'b0;
                end else if (s_cmd == OSD_CMD_STATUS) begin
                    s_acc = {s_acc[23:0], s_in};
                end
                s_idx++;
            end
        end
    end
    always @(negedge sck) begin
        if (!ss) begin
            if (s_bits == 0) s_out = (s_idx > 0 && s_cmd == OSD_CMD_ACK) ? OSD_ACK_BYTE : 8'h00;
            sdi = s_out[3'(7 - s_bits)];
        end
    end
    always @(posedge ss) if (s_cmd == OSD_CMD_STATUS && s_idx == 5) osd_status = s_acc;

    always @(posedge sck1) sck1_cnt++;

    // Payload driver: presents the queue head, withholds it while a stall is requested.
    initial begin
        took = 1'b0;
        forever begin
            @(negedge pclk);
            if (took && tx_q.size() != 0) begin
                void'(tx_q.pop_front());
                popped++;
            end
            if (popped == hold_at && hold_left > 0) begin
                hold_left--;
                ifc.tx_valid = 1'b0;
            end else if (tx_q.size() != 0) begin
                ifc.tx_valid = 1'b1;
                ifc.tx_data  = tx_q[0];
            end else begin
                ifc.tx_valid = 1'b0;
            end
            #1;
            took = ifc.tx_valid && ifc.tx_ready;
            if (ifc.tx_ready) txr_cnt++;
        end
    end

    // Monitor: pops the expected byte whenever rx_valid is seen.
    always @(negedge pclk) begin
        if (ifc.rx_valid) begin
            rx_cnt++;
            if (exp_q.size() == 0) check("rx_unexpected", {24'h0, ifc.rx_data}, 32'hFFFF_FFFF);
            else check("rx_data", {24'h0, ifc.rx_data}, {24'h0, exp_q.pop_front()});
        end
        if (ifc.done) done_cnt++;
        if (ss && ifc.busy) gap_cnt++;
        if (ifc1.tx_ready) txr1++;
        if (ifc1.done) done1++;
        if (ifc1.rx_valid) rx1++;
        if (ss1 && ifc1.busy) gap1++;
    end

    task automatic clr();
        sck_cnt = 0; txr_cnt = 0; done_cnt = 0; rx_cnt = 0; gap_cnt = 0; popped = 0;
        hold_at = -1; hold_left = 0;
    endtask

    task automatic start_cmd(input logic [7:0] c, input int len, input logic rd);
        int n;
        @(negedge pclk);
        ifc.cmd_valid = 1'b1; ifc.cmd_byte = c; ifc.cmd_len = 12'(len); ifc.cmd_rd = rd;
        #1;
        n = 0;
        while (!ifc.cmd_ready && n < 200) begin
            @(negedge pclk); #1; n++;
        end
        check("cmd_accept", n < 200, 1);
        @(negedge pclk);
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int n = 0;
        while ((done_cnt == 0 || ifc.busy) && n < 3000) begin
            @(negedge pclk); n++;
        end
        check(nm, n < 3000, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        osd_enable = 1'b0; osd_status = 32'h0; s_cmd = 8'h00; s_in = 8'h00;
        s_bits = 0; s_idx = 0; s_out = 8'h00; s_acc = 32'h0; sdi = 1'b0;
        ifc.cmd_valid = 1'b0; ifc.cmd_byte = 8'h00; ifc.cmd_len = '0; ifc.cmd_rd = 1'b0;
        ifc.tx_valid = 1'b0; ifc.tx_data = 8'h00;
        ifc1.cmd_valid = 1'b0; ifc1.cmd_byte = 8'h00; ifc1.cmd_len = '0; ifc1.cmd_rd = 1'b0;
        ifc1.tx_valid = 1'b1; ifc1.tx_data = 8'hA5;
        sck1_cnt = 0; txr1 = 0; done1 = 0; rx1 = 0; gap1 = 0;
        clr();
        repeat (3) @(negedge pclk);
        check("rst_ss", ss, 1);
        check("rst_sck", sck, 0);
        check("rst_sdo", sdo, 0);
        check("rst_cmd_ready", ifc.cmd_ready, 0);
        check("rst_tx_ready", ifc.tx_ready, 0);
        check("rst_rx_valid", ifc.rx_valid, 0);
        check("rst_rx_data", {24'h0, ifc.rx_data}, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_done", ifc.done, 0);
        reset = 1'b0;
        #1 check("cmd_ready_at_release", ifc.cmd_ready, 0);
        @(negedge pclk);
        check("cmd_ready_after_release", ifc.cmd_ready, 1);

        // Enable: command byte only.
        clr();
        start_cmd(OSD_CMD_ENABLE, 0, 1'b0);
        wait_end("t1_end");
        check("t1_sck_pulses", sck_cnt, 8);
        check("t1_cmd_seen", {24'h0, s_cmd}, 32'h41);
        check("t1_done", done_cnt, 1);
        check("t1_osd_enable", osd_enable, 1);
        check("t1_tx_ready", txr_cnt, 0);
        check("t1_gap_cycles", gap_cnt, 8);

        // Status store with back-to-back payload.
        clr();
        osd_status = 32'h0;
        tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        start_cmd(OSD_CMD_STATUS, 4, 1'b0);
        wait_end("t2_end");
        check("t2_tx_ready", txr_cnt, 4);
        check("t2_sck_pulses", sck_cnt, 40);
        check("t2_status", osd_status, 32'h12345678);
        check("t2_rx_cnt", rx_cnt, 4);
        check("t2_done", done_cnt, 1);

        // ACK read with filler; a second request while busy must be ignored.
        clr();
        exp_q = '{OSD_ACK_BYTE, OSD_ACK_BYTE};
        start_cmd(OSD_CMD_ACK, 2, 1'b1);
        ifc.cmd_valid = 1'b1; ifc.cmd_byte = OSD_CMD_ENABLE; ifc.cmd_len = '0; ifc.cmd_rd = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge pclk);
            if (ifc.cmd_ready) n++;
        end
        ifc.cmd_valid = 1'b0;
        check("t3_busy_no_ready", n, 0);
        wait_end("t3_end");
        repeat (60) @(negedge pclk);
        check("t3_rx_cnt", rx_cnt, 2);
        check("t3_tx_ready", txr_cnt, 0);
        check("t3_done", done_cnt, 1);
        check("t3_cmd_seen", {24'h0, s_cmd}, 32'h00);
        check("t3_idle", ifc.busy, 0);

        // Status store with byte 3 withheld long enough to stall in FETCH.
        clr();
        osd_status = 32'h0;
        hold_at = 2; hold_left = 84;
        tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        start_cmd(OSD_CMD_STATUS, 4, 1'b0);
        n = 0;
        while (popped < 2 && n < 1000) begin
            @(negedge pclk); n++;
        end
        check("t4_two_taken", n < 1000, 1);
        repeat (74) @(negedge pclk);
        check("t4_stall_sck", sck, 0);
        check("t4_stall_ss", ss, 0);
        check("t4_stall_pulses", sck_cnt, 24);
        check("t4_stall_tx_ready", txr_cnt, 2);
        wait_end("t4_end");
        check("t4_sck_pulses", sck_cnt, 40);
        check("t4_tx_ready", txr_cnt, 4);
        check("t4_status", osd_status, 32'h12345678);

        // Reset in the middle of the first payload byte, then disable.
        clr();
        osd_status = 32'h0;
        tx_q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        start_cmd(OSD_CMD_STATUS, 4, 1'b0);
        n = 0;
        while (sck_cnt < 11 && n < 1000) begin
            @(negedge pclk); n++;
        end
        check("t5_reach_bit3", n < 1000, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_ss", ss, 1);
        check("t5_rst_sck", sck, 0);
        check("t5_rst_busy", ifc.busy, 0);
        check("t5_rst_rx_valid", ifc.rx_valid, 0);
        @(negedge pclk);
        @(negedge pclk);
        #3;
        tx_q.delete();
        reset = 1'b0;
        repeat (40) @(negedge pclk);
        check("t5_no_done", done_cnt, 0);
        check("t5_no_rx", rx_cnt, 0);
        check("t5_status_kept", osd_status, 32'h0);
        clr();
        start_cmd(OSD_CMD_DISABLE, 0, 1'b0);
        wait_end("t5b_end");
        check("t5b_osd_enable", osd_enable, 0);
        check("t5b_done", done_cnt, 1);
        check("t5b_sck_pulses", sck_cnt, 8);

        // Long line write at CLK_DIV=1 on the second instance.
        sck1_cnt = 0; txr1 = 0; done1 = 0; rx1 = 0; gap1 = 0;
        @(negedge pclk);
        ifc1.cmd_valid = 1'b1; ifc1.cmd_byte = OSD_CMD_WRITE | 8'h03; ifc1.cmd_len = 12'd256;
        #1;
        n = 0;
        while (!ifc1.cmd_ready && n < 100) begin
            @(negedge pclk); #1; n++;
        end
        check("t6_cmd_accept", n < 100, 1);
        @(negedge pclk);
        ifc1.cmd_valid = 1'b0;
        n = 0;
        while ((done1 == 0 || ifc1.busy) && n < 6000) begin
            @(negedge pclk); n++;
        end
        check("t6_end", n < 6000, 1);
        check("t6_tx_ready", txr1, 256);
        check("t6_done", done1, 1);
        check("t6_rx_cnt", rx1, 256);
        check("t6_gap_cycles", gap1, 2);
        check("t6_cmd_ready", ifc1.cmd_ready, 1);
        check("t6_sck_pulses", sck1_cnt, 2056);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
